// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bus bundle for mem_port_arbiter.
// It carries the instruction requester, data requester and shared memory port
// signals. Names keep the i/o prefixes as seen from the arbiter.
// Modports:
//   slave  - the arbiter (takes requests and memory read data, drives the rest)
//   master - the environment (CPU buses plus the memory)
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // instruction requester
  logic              iIReadEnable;
  logic [ADDR_W-1:0] iIAddress;
  logic [DATA_W-1:0] oIReadData;
  logic              oIWait;
  logic              oIAck;
  // data requester
  logic              iDReadEnable;
  logic              iDWriteEnable;
  logic [3:0]        iDByteEnable;
  logic [ADDR_W-1:0] iDAddress;
  logic [DATA_W-1:0] iDWriteData;
  logic [DATA_W-1:0] oDReadData;
  logic              oDWait;
  logic              oDAck;
  // shared memory port
  logic              oMReadEnable;
  logic              oMWriteEnable;
  logic [3:0]        oMByteEnable;
  logic [ADDR_W-1:0] oMAddress;
  logic [DATA_W-1:0] oMWriteData;
  logic [DATA_W-1:0] iMReadData;

  modport slave (
    input  iIReadEnable, iIAddress,
    output oIReadData, oIWait, oIAck,
    input  iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    output oDReadData, oDWait, oDAck,
    output oMReadEnable, oMWriteEnable, oMByteEnable, oMAddress, oMWriteData,
    input  iMReadData
  );

  modport master (
    output iIReadEnable, iIAddress,
    input  oIReadData, oIWait, oIAck,
    output iDReadEnable, iDWriteEnable, iDByteEnable, iDAddress, iDWriteData,
    input  oDReadData, oDWait, oDAck,
    input  oMReadEnable, oMWriteEnable, oMByteEnable, oMAddress, oMWriteData,
    output iMReadData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the CPU
// instruction fetch bus (read-only) and the CPU data bus (load/store).
// Accesses are serialised one at a time; each requester sees a wait level
// and a one-cycle ack when its access completes.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   - when both sides request in IDLE, the side not granted last
//               wins (a last-grant flop resets to I, so D wins the first tie)
//   undefined - fixed priority, data over instruction
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no access in flight; grant and op are latched on a request
// ST_ISSUE | one-cycle memory strobe, address/data from the granted side
// ST_WAIT  | read only: counts down READ_LATENCY cycles, captures on zero
// ST_DONE  | one-cycle ack pulse to the granted side
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // counter load so that WAIT lasts exactly READ_LATENCY cycles
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  state_e            state_q, state_d;
  logic              grant_d_q, grant_d_d;   // 1: data side, 0: instruction side
  logic              op_wr_q, op_wr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              m_re_q, m_re_d;
  logic              m_we_q, m_we_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;

  logic              i_req;
  logic              d_req;
  logic              pick_d;
  logic              in_issue;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_be;

  assign i_req = bus.iIReadEnable;
  assign d_req = bus.iDReadEnable | bus.iDWriteEnable;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  // on a tie, data wins unless it was the last side served
  assign pick_d = d_req & (~i_req | ~last_d_q);
`else
  // data over instruction avoids a load/fetch pipeline deadlock
  assign pick_d = d_req;
`endif

  // Next-state and next-output decode for the four-state access sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d_d = grant_d_q;
    op_wr_d   = op_wr_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    m_re_d    = 1'b0;
    m_we_d    = 1'b0;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d  = last_d_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d_d = pick_d;
          // a simultaneous read+write enable on the data side is a write
          op_wr_d   = pick_d & bus.iDWriteEnable;
          m_re_d    = ~(pick_d & bus.iDWriteEnable);
          m_we_d    = pick_d & bus.iDWriteEnable;
          state_d   = ST_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d  = pick_d;
`endif
        end
      end
      ST_ISSUE: begin
        if (op_wr_q) begin
          d_ack_d = grant_d_q;
          i_ack_d = ~grant_d_q;
          state_d = ST_DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (grant_d_q) d_rdata_d = bus.iMReadData;
          else           i_rdata_d = bus.iMReadData;
          d_ack_d = grant_d_q;
          i_ack_d = ~grant_d_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register state, grant, counter and the registered outputs; a reset
  // abandons any access in flight without an ack.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q   <= ST_IDLE;
      grant_d_q <= 1'b0;
      op_wr_q   <= 1'b0;
      cnt_q     <= 4'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      m_re_q    <= 1'b0;
      m_we_q    <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      op_wr_q   <= op_wr_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      m_re_q    <= m_re_d;
      m_we_q    <= m_we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

  // Memory address/data/lanes come live from the granted side during ISSUE
  // only, and are held at zero otherwise.
  always_comb begin
    in_issue = (state_q == ST_ISSUE);
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = 4'b0000;
    if (in_issue) begin
      m_addr  = grant_d_q ? bus.iDAddress : bus.iIAddress;
      m_wdata = grant_d_q ? bus.iDWriteData : '0;
      m_be    = op_wr_q ? bus.iDByteEnable : 4'b1111;
    end
  end

  assign bus.oMAddress     = m_addr;
  assign bus.oMWriteData   = m_wdata;
  assign bus.oMByteEnable  = m_be;
  assign bus.oMReadEnable  = m_re_q;
  assign bus.oMWriteEnable = m_we_q;

  assign bus.oIReadData = i_rdata_q;
  assign bus.oDReadData = d_rdata_q;
  assign bus.oIAck      = i_ack_q;
  assign bus.oDAck      = d_ack_q;

  // combinational so a fresh request stalls its requester in the same cycle
  assign bus.oIWait = i_req & ~i_ack_q;
  assign bus.oDWait = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// transaction-level model (grant, cycles-since-grant, memory array) checked
// every cycle, plus literal expectations that pin that model.
module tb_mem_port_arbiter;
  localparam int RL = 2;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.READ_LATENCY(RL), .ADDR_W(32), .DATA_W(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // memory contents: the environment's truth, updated by the model on writes
  logic [31:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
    mem[8'h40] = 32'hDEADBEEF;
  end

  // memory responder: returns the word READ_LATENCY cycles after a strobe
  int          cyc = 0;
  logic        hist_v [64];
  logic [31:0] hist_a [64];
  always @(posedge iCLK) begin
    cyc++;
    #1;
    if (cyc >= RL && hist_v[(cyc - RL) % 64] === 1'b1)
      bus.iMReadData = mem[hist_a[(cyc - RL) % 64][9:2]];
    else
      bus.iMReadData = 32'hBAD0BAD0;
  end

  // transaction model: k counts cycles since the grant cycle
  bit          mvalid = 0;
  bit          busy   = 0;
  int          k      = 0;
  int          lat    = 0;
  bit          gside  = 0;    // 1: data side
  bit          gwr    = 0;
  bit          last_d = 0;
  logic [31:0] gaddr  = '0;
  logic [31:0] m_ird  = '0;
  logic [31:0] m_drd  = '0;

  always @(negedge iCLK) begin
    logic        e_re, e_we, e_iack, e_dack, ireq, dreq;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    hist_v[cyc % 64] = bus.oMReadEnable;
    hist_a[cyc % 64] = bus.oMAddress;
    ireq = bus.iIReadEnable;
    dreq = bus.iDReadEnable | bus.iDWriteEnable;
    e_re = 0; e_we = 0; e_iack = 0; e_dack = 0; e_be = 0; e_addr = 0; e_wd = 0;
    if (busy && k == 1) begin
      e_re   = !gwr;
      e_we   = gwr;
      e_addr = gside ? bus.iDAddress : bus.iIAddress;
      e_be   = gwr ? bus.iDByteEnable : 4'hF;
      e_wd   = gside ? bus.iDWriteData : 32'h0;
    end
    if (busy && k == lat) begin
      if (gside) e_dack = 1; else e_iack = 1;
      if (!gwr) begin
        if (gside) m_drd = mem[gaddr[9:2]];
        else       m_ird = mem[gaddr[9:2]];
      end
    end
    if (mvalid) begin
      chk("m_re",    {31'b0, bus.oMReadEnable},  {31'b0, e_re});
      chk("m_we",    {31'b0, bus.oMWriteEnable}, {31'b0, e_we});
      chk("m_be",    {28'b0, bus.oMByteEnable},  {28'b0, e_be});
      chk("m_addr",  bus.oMAddress,   e_addr);
      chk("m_wdata", bus.oMWriteData, e_wd);
      chk("i_ack",   {31'b0, bus.oIAck}, {31'b0, e_iack});
      chk("d_ack",   {31'b0, bus.oDAck}, {31'b0, e_dack});
      chk("i_wait",  {31'b0, bus.oIWait}, {31'b0, ireq & ~e_iack});
      chk("d_wait",  {31'b0, bus.oDWait}, {31'b0, dreq & ~e_dack});
      chk("i_rdata", bus.oIReadData, m_ird);
      chk("d_rdata", bus.oDReadData, m_drd);
    end
    // advance to the next cycle
    if (!iRST) begin
      mvalid = 1; busy = 0; k = 0; m_ird = 0; m_drd = 0; last_d = 0;
    end else if (mvalid) begin
      if (busy) begin
        if (k == 1) begin
          gaddr = e_addr;
          if (gwr)
            for (int b = 0; b < 4; b++)
              if (e_be[b]) mem[e_addr[9:2]][8*b +: 8] = e_wd[8*b +: 8];
        end
        if (k == lat) busy = 0;
        else k++;
      end else if (ireq || dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
        gside = dreq && (!ireq || !last_d);
`else
        gside = dreq;
`endif
        gwr    = gside && bus.iDWriteEnable;
        lat    = gwr ? 2 : RL + 2;
        last_d = gside;
        busy   = 1;
        k      = 1;
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge iCLK);
    #1;
  endtask

  initial begin
    bus.iIReadEnable  = 0; bus.iIAddress    = 0;
    bus.iDReadEnable  = 0; bus.iDWriteEnable = 0;
    bus.iDByteEnable  = 0; bus.iDAddress    = 0; bus.iDWriteData = 0;
    iRST = 0;
    tick(); tick();
    iRST = 1;
    mid();
    chk("rst_m_re",  {31'b0, bus.oMReadEnable},  32'd0);
    chk("rst_m_we",  {31'b0, bus.oMWriteEnable}, 32'd0);
    chk("rst_ack",   {30'b0, bus.oIAck, bus.oDAck}, 32'd0);
    chk("rst_i_rd",  bus.oIReadData, 32'd0);
    chk("rst_d_rd",  bus.oDReadData, 32'd0);

    // instruction read at 0x100
    tick(); bus.iIReadEnable = 1; bus.iIAddress = 32'h100;
    mid(); chk("iread_wait_c0", {31'b0, bus.oIWait}, 32'd1);
    tick(); mid();
    chk("iread_strobe_c1", {31'b0, bus.oMReadEnable}, 32'd1);
    chk("iread_addr_c1", bus.oMAddress, 32'h100);
    tick(); tick(); tick(); mid();
    chk("iread_ack_c4", {31'b0, bus.oIAck}, 32'd1);
    chk("iread_data_c4", bus.oIReadData, 32'hDEADBEEF);
    tick(); bus.iIReadEnable = 0; bus.iIAddress = 0;
    tick();

    // data write, lanes 0011
    tick(); bus.iDWriteEnable = 1; bus.iDAddress = 32'h200;
    bus.iDWriteData = 32'h12345678; bus.iDByteEnable = 4'b0011;
    tick(); mid();
    chk("dwr_strobe_c1", {31'b0, bus.oMWriteEnable}, 32'd1);
    chk("dwr_be_c1", {28'b0, bus.oMByteEnable}, 32'h3);
    tick(); mid();
    chk("dwr_ack_c2", {31'b0, bus.oDAck}, 32'd1);
    chk("dwr_rdata", bus.oDReadData, 32'd0);
    tick(); bus.iDWriteEnable = 0; bus.iDByteEnable = 0; bus.iDWriteData = 0;
    tick();

    // collision: both reads, data first
    tick(); bus.iIReadEnable = 1; bus.iIAddress = 32'h104;
    bus.iDReadEnable = 1; bus.iDAddress = 32'h200;
    tick(); mid(); chk("coll_d_addr_c1", bus.oMAddress, 32'h200);
    tick(); tick(); tick(); mid();
    chk("coll_d_ack_c4", {31'b0, bus.oDAck}, 32'd1);
    chk("coll_d_data_c4", bus.oDReadData, 32'hC0DE5678);
    tick(); bus.iDReadEnable = 0;
    tick(); mid();
    chk("coll_i_strobe_c6", {31'b0, bus.oMReadEnable}, 32'd1);
    chk("coll_i_addr_c6", bus.oMAddress, 32'h104);
    tick(); tick(); tick(); mid();
    chk("coll_i_ack_c9", {31'b0, bus.oIAck}, 32'd1);
    chk("coll_i_data_c9", bus.oIReadData, 32'hC0DE0041);
    tick(); bus.iIReadEnable = 0;
    tick();

    // reset during WAIT abandons the read
    tick(); bus.iIReadEnable = 1; bus.iIAddress = 32'h108;
    tick();
    tick(); iRST = 0; bus.iIReadEnable = 0;
    tick(); iRST = 1; mid();
    chk("rstw_ack", {31'b0, bus.oIAck}, 32'd0);
    chk("rstw_i_rd", bus.oIReadData, 32'd0);
    tick(); mid();
    chk("rstw_no_strobe", {31'b0, bus.oMReadEnable}, 32'd0);
    tick(); bus.iIReadEnable = 1;
    tick(); mid(); chk("rstw_reissue_c1", {31'b0, bus.oMReadEnable}, 32'd1);
    tick(); tick(); tick(); mid();
    chk("rstw_ack_c4", {31'b0, bus.oIAck}, 32'd1);
    chk("rstw_data_c4", bus.oIReadData, 32'hC0DE0042);
    tick(); bus.iIReadEnable = 0;
    tick();

    // read and write enables together: write only
    tick(); bus.iDReadEnable = 1; bus.iDWriteEnable = 1; bus.iDAddress = 32'h204;
    bus.iDWriteData = 32'hCAFEF00D; bus.iDByteEnable = 4'hF;
    tick(); mid();
    chk("rw_we_c1", {31'b0, bus.oMWriteEnable}, 32'd1);
    chk("rw_re_c1", {31'b0, bus.oMReadEnable}, 32'd0);
    tick();
    tick(); bus.iDReadEnable = 0; bus.iDWriteEnable = 0; bus.iDByteEnable = 0;
    bus.iDWriteData = 0;
    tick();

    // data read dropped in WAIT still acks once
    tick(); bus.iDReadEnable = 1; bus.iDAddress = 32'h204;
    tick();
    tick(); bus.iDReadEnable = 0;
    tick(); tick(); mid();
    chk("drop_ack_c4", {31'b0, bus.oDAck}, 32'd1);
    chk("drop_data_c4", bus.oDReadData, 32'hCAFEF00D);
    tick(); mid(); chk("drop_ack_c5", {31'b0, bus.oDAck}, 32'd0);

    // back-to-back data writes, one lane each
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.iDWriteEnable = 1; bus.iDAddress = 32'h300 + 32'(4 * i);
      bus.iDWriteData = 32'h11111111 * 32'(i + 1);
      bus.iDByteEnable = 4'(1 << i);
      tick(); tick();
    end
    tick(); bus.iDWriteEnable = 0; bus.iDByteEnable = 0; bus.iDWriteData = 0;
    tick();

    // back-to-back instruction reads of those words
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.iIReadEnable = 1; bus.iIAddress = 32'h300 + 32'(4 * i);
      tick(); tick(); tick(); tick();
    end
    mid(); chk("burst_last_data", bus.oIReadData, 32'h44DE00C3);
    tick(); bus.iIReadEnable = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
